// File: rtl/imm_pkg.sv
// Immediate-type encodings shared by the encode-side packer and the
// decode-side extension unit, so both ends agree on one definition.
package imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/imm_range_check.sv
// Combinational representability check: flags an immediate that would be
// silently truncated when scattered into the chosen instruction format.
module imm_range_check
  import imm_pkg::*;
(
  input  logic [2:0]  imm_type,
  input  logic [31:0] imm,
  output logic        err
);

  // Sign-extension fields must be all-equal; branch/jump offsets must be
  // even; U immediates must have no low-order bits set.
  always_comb begin
    err = 1'b1;
    case (imm_type)
      IMM_I, IMM_S: err = !((&imm[31:11]) || !(|imm[31:11]));
      IMM_B:        err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      IMM_J:        err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      IMM_U:        err = |imm[11:0];
      default:      err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_packer.sv
// Two-stage immediate packer: stage 1 captures the request and its range
// check, stage 2 holds the scattered instruction word until it is taken.
// Saturating counters track emitted words and emitted error words.
module imm_packer
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_type,
  input  logic [31:0]      imm,
  input  logic [31:0]      base_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        s1_valid;
  logic [2:0]  s1_type;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;
  logic        s1_err;
  logic        s2_valid;
  logic        s1_adv;
  logic        s2_adv;
  logic        range_err;
  logic [31:0] packed_word;
  logic        out_fire;

  imm_range_check u_range_check (
    .imm_type (imm_type),
    .imm      (imm),
    .err      (range_err)
  );

  // A stage may move forward when it is empty or its successor is moving.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
    out_fire = s2_valid && out_ready;
  end

  // Stage 1 captures the raw request together with its range-check flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_type  <= 3'b000;
      s1_imm   <= 32'h0;
      s1_base  <= 32'h0;
      s1_err   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_type <= imm_type;
        s1_imm  <= imm;
        s1_base <= base_instr;
        s1_err  <= range_err;
      end
    end
  end

  // Scatter the stage-1 immediate into its format's field positions; any bit
  // not owned by the immediate keeps the base instruction's value.
  always_comb begin
    packed_word = s1_base;
    case (s1_type)
      IMM_I: packed_word[31:20] = s1_imm[11:0];
      IMM_S: begin
        packed_word[31:25] = s1_imm[11:5];
        packed_word[11:7]  = s1_imm[4:0];
      end
      IMM_B: begin
        packed_word[31]    = s1_imm[12];
        packed_word[30:25] = s1_imm[10:5];
        packed_word[11:8]  = s1_imm[4:1];
        packed_word[7]     = s1_imm[11];
      end
      IMM_U: packed_word[31:12] = s1_imm[31:12];
      IMM_J: begin
        packed_word[31]    = s1_imm[20];
        packed_word[30:21] = s1_imm[10:1];
        packed_word[20]    = s1_imm[11];
        packed_word[19:12] = s1_imm[19:12];
      end
      default: packed_word = s1_base;
    endcase
  end

  // Stage 2 holds the finished word; it only changes when allowed to advance,
  // which keeps instr/err stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      instr    <= 32'h0;
      err      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        instr <= packed_word;
        err   <= s1_err;
      end
    end
  end

  assign out_valid = s2_valid;

  // Saturating statistics; a clear wins over a simultaneous increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (clr_cnt) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (out_fire) begin
      if (pkt_cnt != CNT_MAX) pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (err && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/imm_packer.md
Name: imm_packer

Overview:
- Inverse of the decode-side immediate extension: takes a 32-bit signed/unsigned immediate, an immediate type and a base instruction word.
- Scatters the immediate into the RISC-V I/S/B/U/J field positions and flags immediates that cannot be represented in that type.
- Used by the instruction-memory loader / test-program builder to emit encoded words.
- Two-stage valid/ready pipeline with backpressure, plus saturating statistics counters.

Parameters:
- CNT_W, 16, width of the packed-word and error counters

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept this cycle
- imm_type  in  3  I=000, S=001, J=010, B=011, U=100; 101-111 illegal
- imm  in  32  immediate value, two's complement except U (upper 20 bits used)
- base_instr  in  32  opcode/rd/rs/funct bits; immediate field positions are overwritten
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts this cycle
- instr  out  32  packed instruction word
- err  out  1  immediate not representable in imm_type, or illegal type
- clr_cnt  in  1  synchronous clear of both counters
- pkt_cnt  out  CNT_W  output handshakes since reset/clear, saturating
- err_cnt  out  CNT_W  output handshakes with err=1, saturating

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, instr=0, err=0, pkt_cnt=0, err_cnt=0. A mid-operation reset discards in-flight words with no output.
- Handshakes: transfer occurs when valid&&ready at a clock edge. s2_adv = !s2_valid || out_ready. s1_adv = !s1_valid || s2_adv. in_ready = s1_adv, combinational and not dependent on in_valid.
- Stage 1 registers imm_type, imm, base_instr and the range-check result.
- Stage 2 registers the packed instr and err. out_valid = s2_valid.
- Latency: a word accepted at edge N is presented at edge N+2 if there is no stall.
- Throughput: 1 word/clk when out_ready=1. Order is preserved; no drop or duplication under any out_ready pattern.
- Holding: while out_valid && !out_ready, instr and err are held stable.
- Field mapping; all other bits come from base_instr:
  - I: instr[31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - U: [31:12]=imm[31:12]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - Illegal type: instr=base_instr, err=1.
- Range check (err=1 when violated):
  - I/S: imm[31:11] all equal
  - B: imm[31:12] all equal and imm[0]=0
  - J: imm[31:20] all equal and imm[0]=0
  - U: imm[11:0]=0
- On err the word is still packed using truncated bits and still emitted.
- Counters:
  - Each output handshake increments pkt_cnt, and also err_cnt if err=1.
  - Both saturate at all-ones.
  - clr_cnt has priority over a same-cycle increment: the result is 0.

Decomposition:
- Shared package imm_pkg: localparams IMM_I/S/J/B/U (3-bit encodings above), shared with the decode-side extension unit so both ends use one definition.
- One combinational sub-module imm_range_check (imm_type, imm -> err), instantiated in stage 1.
- Field scatter and pipeline stay in imm_packer.

Test Plan:
- I: base 0x00000013, imm 0xFFFFFFFF -> instr 0xFFF00013, err 0, out_valid two edges after accept.
- S: base 0x00002023, imm 0x000007FF -> 0x7E002FA3, err 0.
- B: base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3. U: base 0x00000037, imm 0x12345000 -> 0x12345037. J: base 0x0000006F, imm 0x00000800 -> 0x0010006F. All err 0.
- Errors:
  - I, imm 0x00000800 -> instr 0x80000013, err 1.
  - B, imm 0x00000003 -> err 1.
  - type 101 -> instr=base_instr, err 1.
  - After these three, err_cnt=3.
- Backpressure: out_ready=0 while offering 3 words -> in_ready low after 2 accepts. Then out_ready=1 -> 3 words out in order on consecutive cycles; pkt_cnt +3.
- Reset with both stages valid -> out_valid=0 and counters 0 before the next edge. Also: clr_cnt together with an output handshake -> counters read 0.
